bcd2bin: RTL and testbench
==========================

# bcd2bin

Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3 from any BCD digit ≥ 8). It is the inverse of the display path's binary-to-BCD stage. It takes packed BCD digits from keypad or entry logic and returns a plain binary value to the datapath. It uses a valid/ready handshake on both sides and runs one conversion at a time.

## Interface
Parameters:
- BCD_CNT, default 3: number of BCD digits in the input.
- BIN_WIDTH, default 10: binary output width. Must satisfy 2^BIN_WIDTH > 10^BCD_CNT − 1. Wider values are zero-extended.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: reset, asynchronous assert, active low.
- in_valid, input, 1: bcd_in holds a word to convert.
- in_ready, output, 1: converter can accept a word.
- bcd_in, input, 4*BCD_CNT: packed digits, digit i in bits [4i+3:4i], digit 0 least significant.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer takes the result.
- bin_out, output, BIN_WIDTH: binary result.
- err, output, 1: at least one input digit was > 9. Only functional with BCD2BIN_CHECK_EN.

## Operation
- Working register S = {bcd part (4*BCD_CNT bits), bin part (4*BCD_CNT bits)}. Step counter cnt counts 0 … 4*BCD_CNT−1.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: S ← {bcd_in, 0}, cnt ← 0, capture the digit-check flag, go to CONV.
- CONV, once per cycle:
  - Shift S right by 1, so the bcd LSB enters the bin MSB.
  - Then, for each 4-bit digit of the shifted bcd part, if the digit ≥ 8, subtract 3. All digits are corrected in parallel, combinationally, within the same cycle.
  - When cnt == 4*BCD_CNT−1, go to DONE; otherwise cnt+1.
- DONE:
  - out_valid = 1.
  - bin_out = low BIN_WIDTH bits of the bin part, zero-extended if BIN_WIDTH > 4*BCD_CNT.
  - bin_out and err hold stable until out_valid && out_ready; then go to IDLE.
- in_valid is ignored outside IDLE; no input queuing.
- in_ready and out_valid are pure state decodes, with no combinational path from in_valid or out_ready.
- Reset values: state IDLE, S = 0, cnt = 0, in_ready = 1, out_valid = 0, bin_out = 0, err = 0.
- Reset mid-conversion or in DONE: the result is discarded immediately (asynchronous). The first acceptance can occur at the first clock edge after rst_n deasserts.

## Timing
- Acceptance edge T0.
- Shift edges T0+1 … T0+4*BCD_CNT. out_valid is high after edge T0+4*BCD_CNT, i.e. 12 cycles after T0 at default parameters.
- With out_ready held high, out_valid falls and in_ready rises at the next edge. The next acceptance is at the earliest one edge later.
- Minimum initiation interval is 4*BCD_CNT+2 cycles, 14 at default.
- out_ready low stalls DONE indefinitely with outputs frozen.

## Configuration
- BCD2BIN_CHECK_EN defined:
  - At acceptance, err_flag ← OR over digits of (digit > 9).
  - In DONE, err = err_flag. When err = 1, bin_out is forced to 0.
  - The conversion still consumes the full cycle count, so latency is unchanged.
- BCD2BIN_CHECK_EN undefined:
  - No check logic. err is tied to 0.
  - bin_out is the raw algorithm result for any input, including non-BCD nibbles.

## Test plan
- Reset: rst_n low → in_ready=1, out_valid=0, bin_out=0, err=0. Pulse rst_n low mid-CONV → same values immediately, and the next word converts correctly.
- Full sweep, default parameters: bcd_in 0x000…0x999 in BCD order, out_ready=1 → bin_out equals the decimal value, e.g. 0x999→999 (0x3E7), 0x255→255, 0x010→10. out_valid arrives exactly 12 cycles after acceptance.
- Backpressure: convert 0x128 with out_ready=0 for 20 cycles → out_valid stays 1, bin_out stays 128, in_ready stays 0, and a new in_valid is ignored. Raising out_ready → handshake completes, in_ready=1 on the next cycle.
- Back-to-back: in_valid held high with 0x001 then 0x998, out_ready=1 → results 1 then 998, acceptances 14 cycles apart.
- Invalid digit, with BCD2BIN_CHECK_EN: 0x1A3 → err=1, bin_out=0. 0x909 → err=0, bin_out=909. Without the macro: err=0 for all inputs.
- Parameter variant BCD_CNT=4, BIN_WIDTH=14: 0x9999 → 9999 at 16 cycles latency; 0x0000 → 0.

Source files
------------

// File: rtl/bcd2bin.sv
// bcd2bin: sequential BCD-to-binary converter (reverse double-dabble).
//
// A packed BCD word is loaded into the upper half of a working register.
// Each CONV cycle shifts the register right by one bit. Then 3 is subtracted
// from every BCD digit that has reached 8 or more. After 4*BCD_CNT steps the
// lower half holds the binary value.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   bcd_in holds a word to convert
//   in_ready   converter can accept a word (high in IDLE only)
//   bcd_in     packed digits, digit i in bits [4i+3:4i], digit 0 least significant
//   out_valid  result available (high in DONE only)
//   out_ready  consumer takes the result
//   bin_out    binary result, zero-extended when BIN_WIDTH > 4*BCD_CNT
//   err        an input digit was > 9 (functional only with BCD2BIN_CHECK_EN)
//
// Configuration macro:
//   BCD2BIN_CHECK_EN  enables the digit-range check. A flagged word reports
//                     err=1 with bin_out forced to 0. Latency is unchanged.

module bcd2bin #(
  parameter int BCD_CNT   = 3,
  parameter int BIN_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*BCD_CNT-1:0]   bcd_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIN_WIDTH-1:0]   bin_out,
  output logic                   err
);

  localparam int W  = 4 * BCD_CNT;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [2*W-1:0]         s_r;
  logic [2*W-1:0]         s_step_s;
  logic [CW-1:0]          cnt_r;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic [BIN_WIDTH-1:0]   bin_out_r;
  logic [BIN_WIDTH-1:0]   bin_res_s;

  // One reverse double-dabble step. Shift right, then correct each bcd digit.
  // After the shift, a digit >= 8 can only come from the bit that the next
  // digit shifted in. That bit is worth 5 in decimal but 8 in binary, so the
  // correction subtracts 3.
  function automatic logic [2*W-1:0] dabble_step(input logic [2*W-1:0] s);
    logic [2*W-1:0] t;
    logic [3:0]     d;
    t = s >> 1;
    for (int i = 0; i < BCD_CNT; i++) begin
      d = t[W + 4*i +: 4];
      t[W + 4*i +: 4] = (d >= 4'd8) ? (d - 4'd3) : d;
    end
    return t;
  endfunction

  // Fit the W-bit bin part to BIN_WIDTH. Wider outputs are zero-extended.
  // Narrower outputs keep the low bits.
  function automatic logic [BIN_WIDTH-1:0] fit_bin(input logic [W-1:0] b);
    logic [BIN_WIDTH+W-1:0] t;
    t = {{BIN_WIDTH{1'b0}}, b};
    return t[BIN_WIDTH-1:0];
  endfunction

`ifdef BCD2BIN_CHECK_EN
  logic err_flag_r;
  logic err_r;

  // Digit-range check: the word is flagged if any nibble is greater than 9.
  function automatic logic digit_err(input logic [W-1:0] bcd);
    logic e;
    e = 1'b0;
    for (int i = 0; i < BCD_CNT; i++) begin
      e = e | (bcd[4*i +: 4] > 4'd9);
    end
    return e;
  endfunction
`endif

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: if (in_valid && in_ready_r) state_s = CONV; else state_s = IDLE;
      CONV: if (cnt_r == CNT_LAST)      state_s = DONE; else state_s = CONV;
      DONE: if (out_ready)              state_s = IDLE; else state_s = DONE;
      default:                          state_s = IDLE;
    endcase
  end

  // Compute the next shift step, and the result the final step will produce.
  always_comb begin
    s_step_s = dabble_step(s_r);
`ifdef BCD2BIN_CHECK_EN
    if (err_flag_r) bin_res_s = {BIN_WIDTH{1'b0}};
    else            bin_res_s = fit_bin(s_step_s[W-1:0]);
`else
    bin_res_s = fit_bin(s_step_s[W-1:0]);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Working register and step counter: load on acceptance, shift in CONV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r   <= {(2*W){1'b0}};
      cnt_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            s_r   <= {bcd_in, {W{1'b0}}};
            cnt_r <= {CW{1'b0}};
          end
        end
        CONV: begin
          s_r <= s_step_s;
          if (cnt_r != CNT_LAST) cnt_r <= cnt_r + CNT_ONE;
        end
        DONE:    s_r <= s_r;
        default: s_r <= s_r;
      endcase
    end
  end

`ifdef BCD2BIN_CHECK_EN
  // Digit-check flag: capture at acceptance, report while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      if (state_r == IDLE && in_valid && in_ready_r) err_flag_r <= digit_err(bcd_in);
      if (state_r == CONV && state_s == DONE) err_r <= err_flag_r;
      else if (state_s != DONE)               err_r <= 1'b0;
    end
  end
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  // Registered handshake and result outputs. in_ready and out_valid follow
  // the next state, so they are decodes of the state register one cycle on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      bin_out_r   <= {BIN_WIDTH{1'b0}};
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      if (state_r == CONV && state_s == DONE) bin_out_r <= bin_res_s;
      else if (state_s != DONE)               bin_out_r <= {BIN_WIDTH{1'b0}};
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign bin_out   = bin_out_r;

endmodule

// File: tb/tb_bcd2bin.sv
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] bcd_in = 12'h000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [9:0]  bin_out;
  logic        err;

  logic        in4_valid = 1'b0;
  logic        in4_ready;
  logic [15:0] bcd4 = 16'h0000;
  logic        out4_valid;
  logic        out4_ready = 1'b1;
  logic [13:0] bin4;
  logic        err4;

  bcd2bin #(.BCD_CNT(3), .BIN_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bcd_in(bcd_in), .out_valid(out_valid), .out_ready(out_ready),
    .bin_out(bin_out), .err(err)
  );

  bcd2bin #(.BCD_CNT(4), .BIN_WIDTH(14)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in4_valid), .in_ready(in4_ready),
    .bcd_in(bcd4), .out_valid(out4_valid), .out_ready(out4_ready),
    .bin_out(bin4), .err(err4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int acc_q[$];
  logic [9:0] res_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log acceptance edges and delivered results of the main instance.
  always @(posedge clk) begin
    if (in_valid && in_ready) acc_q.push_back(cyc);
    if (out_valid && out_ready) res_q.push_back(bin_out);
  end

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
  } vec_t;

  vec_t tbl[12];

  logic [15:0] w4[2] = '{16'h9999, 16'h0000};
  int          e4[2] = '{9999, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: value = sum(digit_i * 10^i), reduced modulo 2^10. With the
  // check enabled, any nibble above 9 yields err=1 and a result of 0.
  function automatic void ref_conv(input logic [11:0] v, output logic [9:0] b, output logic e);
    int val;
    int d;
    logic [11:0] t;
    val = 0;
    e = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      t = v >> (4 * i);
      d = int'(t[3:0]);
      val = val * 10 + d;
      if (d > 9) e = 1'b1;
    end
`ifdef BCD2BIN_CHECK_EN
    b = e ? 10'd0 : 10'(val % 1024);
`else
    e = 1'b0;
    b = 10'(val % 1024);
`endif
  endfunction

  // Offer one word and wait for the result. If out_ready is high, the
  // handshake edge is also consumed.
  task automatic run_one(input logic [11:0] v, output logic [9:0] b, output logic e, output int lat);
    int n;
    n = 0;
    bcd_in = v;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (in_ready !== 1'b1) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    b = bin_out;
    e = err;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic conv_check(input string name, input logic [11:0] v, input logic [9:0] eb, input logic ee);
    logic [9:0] b;
    logic e;
    int lat;
    run_one(v, b, e, lat);
    check({name, "_bin"}, 32'(b), 32'(eb));
    check({name, "_err"}, 32'(e), 32'(ee));
    check({name, "_lat"}, lat, 32'd12);
  endtask

  initial begin
    logic [9:0]  rb;
    logic        re;
    logic [11:0] v;
    int          n;

    tbl[0] = '{12'h000, 10'd0,   1'b0};
    tbl[1] = '{12'h999, 10'd999, 1'b0};
    tbl[2] = '{12'h255, 10'd255, 1'b0};
    tbl[3] = '{12'h010, 10'd10,  1'b0};
    tbl[4] = '{12'h128, 10'd128, 1'b0};
    tbl[5] = '{12'h001, 10'd1,   1'b0};
    tbl[6] = '{12'h998, 10'd998, 1'b0};
    tbl[7] = '{12'h909, 10'd909, 1'b0};
    tbl[8] = '{12'h500, 10'd500, 1'b0};
    tbl[9] = '{12'h099, 10'd99,  1'b0};
`ifdef BCD2BIN_CHECK_EN
    tbl[10] = '{12'h1A3, 10'd0, 1'b1};
    tbl[11] = '{12'hFFF, 10'd0, 1'b1};
`else
    tbl[10] = '{12'h1A3, 10'd203, 1'b0};
    tbl[11] = '{12'hFFF, 10'd641, 1'b0};
`endif

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) conv_check("tbl", tbl[i].bcd, tbl[i].bin, tbl[i].err);

    // Full BCD sweep; the expected value is the decimal number itself.
    for (int i = 0; i < 1000; i++) begin
      v = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      conv_check("sweep", v, 10'(i), 1'b0);
    end

    // Random words, including non-BCD nibbles.
    for (int i = 0; i < 200; i++) begin
      v = 12'($urandom_range(0, 4095));
      ref_conv(v, rb, re);
      conv_check("rand", v, rb, re);
    end

    // Backpressure: hold DONE for 20 cycles while a new word is offered.
    out_ready = 1'b0;
    begin
      int lat;
      run_one(12'h128, rb, re, lat);
      check("bp_lat", lat, 32'd12);
    end
    bcd_in = 12'h555;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_bin_out", 32'(bin_out), 32'd128);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    repeat (16) @(posedge clk);
    #1;
    check("bp_no_ghost", 32'(out_valid), 32'd0);

    // Back-to-back with in_valid held high.
    acc_q.delete();
    res_q.delete();
    bcd_in = 12'h001;
    in_valid = 1'b1;
    n = 0;
    while (acc_q.size() < 1 && n < 40) begin @(posedge clk); #1; n++; end
    bcd_in = 12'h998;
    n = 0;
    while (acc_q.size() < 2 && n < 40) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    n = 0;
    while (res_q.size() < 2 && n < 40) begin @(posedge clk); #1; n++; end
    check("b2b_accepts", acc_q.size(), 32'd2);
    check("b2b_results", res_q.size(), 32'd2);
    if (acc_q.size() >= 2) check("b2b_interval", acc_q[1] - acc_q[0], 32'd14);
    if (res_q.size() >= 2) begin
      check("b2b_res0", 32'(res_q[0]), 32'd1);
      check("b2b_res1", 32'(res_q[1]), 32'd998);
    end

    // Reset pulse in the middle of a conversion.
    bcd_in = 12'h777;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bin_out", 32'(bin_out), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    conv_check("after_rst", 12'h456, 10'd456, 1'b0);

    // Four-digit instance.
    for (int k = 0; k < 2; k++) begin
      int lat;
      bcd4 = w4[k];
      in4_valid = 1'b1;
      n = 0;
      while (in4_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in4_valid = 1'b0;
      lat = 0;
      while (out4_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
      check("w4_bin", 32'(bin4), 32'(e4[k]));
      check("w4_err", 32'(err4), 32'd0);
      check("w4_lat", lat, 32'd16);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
